// File: rtl/fwd_mux_reg_pkg.sv
// Shared Y86 pipeline definitions for the decode->execute forwarding register:
// bubble default value and the stall/bubble control encoding.
package fwd_mux_reg_pkg;

  localparam logic [31:0] Y86_BUB_VAL = 32'h0000_0000;

  typedef enum logic [1:0] {
    CTL_LOAD     = 2'd0,
    CTL_BUBBLE   = 2'd1,
    CTL_STALL    = 2'd2,
    CTL_CONFLICT = 2'd3
  } pipe_ctl_e;

  // Stall dominates bubble; asserting both is a control conflict that still holds.
  function automatic pipe_ctl_e decode_ctl(input logic stall, input logic bubble);
    if (stall && bubble) return CTL_CONFLICT;
    else if (stall)      return CTL_STALL;
    else if (bubble)     return CTL_BUBBLE;
    else                 return CTL_LOAD;
  endfunction

endpackage

// File: rtl/fwd_mux_reg_prio_enc.sv
// Combinational priority encoder: lowest-index asserted hit wins.
module prio_enc #(
  parameter int NSRC  = 4,
  parameter int SEL_W = 2
) (
  input  logic [NSRC-1:0]  src_hit,
  output logic             any_hit,
  output logic [SEL_W-1:0] idx
);

  // Scanning downward lets the lowest asserted index overwrite the others.
  always_comb begin
    any_hit = |src_hit;
    idx     = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_hit[i]) idx = SEL_W'(i);
    end
  end

endmodule

// File: rtl/fwd_mux_reg.sv
// N-source priority forwarding mux feeding a Y86 decode->execute pipeline
// register with stall/bubble control, a forwarding-event counter and error flag.
module fwd_mux_reg
  import fwd_mux_reg_pkg::*;
#(
  parameter int             W       = 32,
  parameter int             NSRC    = 4,
  parameter int             SEL_W   = 2,
  parameter logic [W-1:0]   BUB_VAL = W'(Y86_BUB_VAL),
  parameter int             CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [W-1:0]      dflt,
  input  logic [NSRC*W-1:0] src_data,
  input  logic [NSRC-1:0]   src_hit,
  input  logic              stall,
  input  logic              bubble,
  input  logic              cnt_clr,
  output logic [W-1:0]      q,
  output logic              q_fwd,
  output logic [SEL_W-1:0]  q_src,
  output logic [CNT_W-1:0]  fwd_cnt,
  output logic              ctl_err
);

  logic             any_hit_p0;
  logic [SEL_W-1:0] win_p0;
  logic [W-1:0]     sel_data_p0;
  pipe_ctl_e        ctl_p0;
  logic             fwd_load_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // ---- stage p0: combinational select ----
  prio_enc #(
    .NSRC  (NSRC),
    .SEL_W (SEL_W)
  ) u_prio_enc (
    .src_hit (src_hit),
    .any_hit (any_hit_p0),
    .idx     (win_p0)
  );

  // Only the winning slice is ever routed, so unknowns on losing sources stay out of q.
  always_comb begin
    sel_data_p0 = dflt;
    for (int i = 0; i < NSRC; i++) begin
      if (any_hit_p0 && (win_p0 == SEL_W'(i))) sel_data_p0 = src_data[i*W +: W];
    end
  end

  assign ctl_p0      = decode_ctl(stall, bubble);
  assign fwd_load_p0 = (ctl_p0 == CTL_LOAD) && any_hit_p0;

  // ---- stage p1: pipeline register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q     <= BUB_VAL;
      q_fwd <= 1'b0;
      q_src <= '0;
    end else begin
      unique case (ctl_p0)
        CTL_LOAD: begin
          q     <= sel_data_p0;
          q_fwd <= any_hit_p0;
          q_src <= win_p0;
        end
        CTL_BUBBLE: begin
          q     <= BUB_VAL;
          q_fwd <= 1'b0;
          q_src <= '0;
        end
        CTL_STALL, CTL_CONFLICT: begin
          q     <= q;
          q_fwd <= q_fwd;
          q_src <= q_src;
        end
        default: begin
          q     <= q;
          q_fwd <= q_fwd;
          q_src <= q_src;
        end
      endcase
    end
  end

  // Clear wins over both increment and stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         fwd_cnt <= '0;
    else if (cnt_clr)     fwd_cnt <= '0;
    else if (fwd_load_p0) fwd_cnt <= sat_inc(fwd_cnt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    ctl_err <= 1'b0;
    else if (ctl_p0 == CTL_CONFLICT) ctl_err <= 1'b1;
  end

endmodule

// File: tb/tb_fwd_mux_reg.sv
// Randomised and directed bench for fwd_mux_reg (NSRC=4, W=32, CNT_W=4).
module tb_fwd_mux_reg;

  localparam int W     = 32;
  localparam int NSRC  = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [W-1:0]      dflt;
  logic [W-1:0]      src_arr [NSRC];
  logic [NSRC*W-1:0] src_data;
  logic [NSRC-1:0]   src_hit;
  logic              stall, bubble, cnt_clr;
  logic [W-1:0]      q;
  logic              q_fwd;
  logic [SEL_W-1:0]  q_src;
  logic [CNT_W-1:0]  fwd_cnt;
  logic              ctl_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0]     m_q;
  logic             m_fwd;
  logic [SEL_W-1:0] m_src;
  int               m_cnt;
  logic             m_err;

  assign src_data = {src_arr[3], src_arr[2], src_arr[1], src_arr[0]};

  always #5 clk = ~clk;

  fwd_mux_reg #(
    .W     (W),
    .NSRC  (NSRC),
    .SEL_W (SEL_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .dflt     (dflt),
    .src_data (src_data),
    .src_hit  (src_hit),
    .stall    (stall),
    .bubble   (bubble),
    .cnt_clr  (cnt_clr),
    .q        (q),
    .q_fwd    (q_fwd),
    .q_src    (q_src),
    .fwd_cnt  (fwd_cnt),
    .ctl_err  (ctl_err)
  );

  // Lowest set bit isolated arithmetically, then converted to its index.
  function automatic int winner(input logic [NSRC-1:0] h);
    logic [NSRC-1:0] low;
    low = h & (~h + 1'b1);
    return $clog2(low);
  endfunction

  task automatic model_reset();
    m_q = '0; m_fwd = 1'b0; m_src = '0; m_cnt = 0; m_err = 1'b0;
  endtask

  task automatic model_step();
    int w;
    w = winner(src_hit);
    if (stall) begin
      if (bubble) m_err = 1'b1;
    end else if (bubble) begin
      m_q = '0; m_fwd = 1'b0; m_src = '0;
    end else begin
      m_fwd = |src_hit;
      m_src = m_fwd ? SEL_W'(w) : '0;
      m_q   = m_fwd ? src_arr[w] : dflt;
    end
    if (cnt_clr) m_cnt = 0;
    else if (!stall && !bubble && (|src_hit)) m_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic rand_src();
    for (int i = 0; i < NSRC; i++) src_arr[i] = $urandom;
    dflt = $urandom;
  endtask

  task automatic idle_ctl();
    stall = 1'b0; bubble = 1'b0; cnt_clr = 1'b0; src_hit = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_ctl();
    rand_src();
    model_reset();
    #12;
    n_tests++; if (q !== 32'h0) begin n_fail++; $display("FAIL reset_q got=%h exp=%h", q, 32'h0); end
    n_tests++; if (q_fwd !== 1'b0) begin n_fail++; $display("FAIL reset_q_fwd got=%b exp=0", q_fwd); end
    n_tests++; if (q_src !== 2'd0) begin n_fail++; $display("FAIL reset_q_src got=%0d exp=0", q_src); end
    n_tests++; if (fwd_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", fwd_cnt); end
    n_tests++; if (ctl_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", ctl_err); end
  endtask

  task automatic test_idle();
    reset_n = 1'b1;
    src_hit = '0;
    dflt    = 32'd5;
    cycle();
    n_tests++; if (q !== 32'd5) begin n_fail++; $display("FAIL idle_q got=%h exp=%h", q, 32'd5); end
    n_tests++; if (q_fwd !== 1'b0) begin n_fail++; $display("FAIL idle_q_fwd got=%b exp=0", q_fwd); end
  endtask

  task automatic test_priority();
    rand_src();
    src_arr[0] = 'x;
    src_arr[1] = 32'hAA;
    src_arr[3] = 32'hCC;
    src_hit    = 4'b1010;
    cycle();
    n_tests++; if (q !== 32'hAA) begin n_fail++; $display("FAIL prio_q got=%h exp=%h", q, 32'hAA); end
    n_tests++; if (q_src !== 2'd1) begin n_fail++; $display("FAIL prio_q_src got=%0d exp=1", q_src); end
    n_tests++; if (q_fwd !== 1'b1) begin n_fail++; $display("FAIL prio_q_fwd got=%b exp=1", q_fwd); end
    n_tests++; if (fwd_cnt !== 4'd1) begin n_fail++; $display("FAIL prio_cnt got=%0d exp=1", fwd_cnt); end
  endtask

  task automatic test_stall_bubble();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_src();
      src_hit = 4'($urandom);
      cycle();
      n_tests++; if (q !== 32'hAA || q_src !== 2'd1) begin
        n_fail++; $display("FAIL stall_hold k=%0d got q=%h src=%0d exp q=%h src=1", k, q, q_src, 32'hAA);
      end
      n_tests++; if (fwd_cnt !== 4'd1) begin n_fail++; $display("FAIL stall_cnt k=%0d got=%0d exp=1", k, fwd_cnt); end
    end
    stall   = 1'b0;
    bubble  = 1'b1;
    src_hit = 4'b0001;
    cycle();
    n_tests++; if (q !== 32'h0 || q_fwd !== 1'b0 || q_src !== 2'd0) begin
      n_fail++; $display("FAIL bubble got q=%h fwd=%b src=%0d exp q=0 fwd=0 src=0", q, q_fwd, q_src);
    end
    bubble = 1'b0;
  endtask

  task automatic test_conflict();
    rand_src();
    src_arr[0] = 32'h55;
    src_hit    = 4'b0001;
    cycle();
    stall   = 1'b1;
    bubble  = 1'b1;
    src_hit = 4'b0100;
    cycle();
    n_tests++; if (q !== 32'h55) begin n_fail++; $display("FAIL conflict_hold got=%h exp=%h", q, 32'h55); end
    n_tests++; if (ctl_err !== 1'b1) begin n_fail++; $display("FAIL conflict_err got=%b exp=1", ctl_err); end
    stall   = 1'b0;
    bubble  = 1'b0;
    src_hit = '0;
    dflt    = 32'd9;
    cycle();
    n_tests++; if (ctl_err !== 1'b1 || q !== 32'd9) begin
      n_fail++; $display("FAIL conflict_sticky got err=%b q=%h exp err=1 q=%h", ctl_err, q, 32'd9);
    end
  endtask

  task automatic test_counter();
    cnt_clr = 1'b1;
    src_hit = '0;
    cycle();
    n_tests++; if (fwd_cnt !== 4'd0) begin n_fail++; $display("FAIL cnt_clear got=%0d exp=0", fwd_cnt); end
    cnt_clr = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      rand_src();
      src_hit = 4'($urandom_range(1, 15));
      cycle();
      n_tests++; if (fwd_cnt !== 4'((k > CMAX) ? CMAX : k) || q !== m_q) begin
        n_fail++; $display("FAIL cnt_load k=%0d got cnt=%0d q=%h exp cnt=%0d q=%h",
                           k, fwd_cnt, q, (k > CMAX) ? CMAX : k, m_q);
      end
    end
    n_tests++; if (fwd_cnt !== 4'd15) begin n_fail++; $display("FAIL cnt_sat got=%0d exp=15", fwd_cnt); end
    rand_src();
    cnt_clr = 1'b1;
    src_hit = 4'b0100;
    cycle();
    n_tests++; if (fwd_cnt !== 4'd0 || q !== src_arr[2] || q_fwd !== 1'b1) begin
      n_fail++; $display("FAIL cnt_clr_hit got cnt=%0d q=%h fwd=%b exp cnt=0 q=%h fwd=1",
                         fwd_cnt, q, q_fwd, src_arr[2]);
    end
    cnt_clr = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      rand_src();
      src_hit = 4'($urandom);
      stall   = ($urandom % 5) == 0;
      bubble  = ($urandom % 6) == 0;
      cnt_clr = ($urandom % 25) == 0;
      cycle();
      n_tests++;
      if ({q, q_fwd, q_src, fwd_cnt, ctl_err} !== {m_q, m_fwd, m_src, 4'(m_cnt), m_err}) begin
        n_fail++;
        $display("FAIL random k=%0d got q=%h fwd=%b src=%0d cnt=%0d err=%b exp q=%h fwd=%b src=%0d cnt=%0d err=%b",
                 k, q, q_fwd, q_src, fwd_cnt, ctl_err, m_q, m_fwd, m_src, m_cnt, m_err);
      end
    end
    idle_ctl();
  endtask

  task automatic test_async_reset();
    rand_src();
    src_arr[1] = 32'hAA;
    src_hit    = 4'b0010;
    cycle();
    n_tests++; if (q !== 32'hAA) begin n_fail++; $display("FAIL areset_pre got=%h exp=%h", q, 32'hAA); end
    stall = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    n_tests++; if (q !== 32'h0 || q_fwd !== 1'b0 || q_src !== 2'd0 || fwd_cnt !== 4'd0 || ctl_err !== 1'b0) begin
      n_fail++; $display("FAIL areset_mid got q=%h fwd=%b src=%0d cnt=%0d err=%b exp all zero",
                         q, q_fwd, q_src, fwd_cnt, ctl_err);
    end
    #2;
    reset_n = 1'b1;
    stall   = 1'b0;
    src_hit = '0;
    dflt    = 32'd7;
    cycle();
    n_tests++; if (q !== 32'd7 || q_fwd !== 1'b0) begin
      n_fail++; $display("FAIL areset_after got q=%h fwd=%b exp q=%h fwd=0", q, q_fwd, 32'd7);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle();
    test_priority();
    test_stall_bubble();
    test_conflict();
    test_counter();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
